// File: rtl/cache_tag_array.sv
// Set-associative tag store: parallel tag compare, dirty tracking, fill victim selection.
// One-cycle registered response; a post-reset sequencer clears one set per cycle while busy.
module cache_tag_array #(
  parameter  int TAG_W   = 4,
  parameter  int INDEX_W = 10,
  parameter  int WAYS    = 2,
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req_valid,
  input  logic [1:0]         i_req_op,
  input  logic [INDEX_W-1:0] i_req_index,
  input  logic [TAG_W-1:0]   i_req_tag,
  input  logic               i_req_dirty,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_resp_valid,
  output logic               o_resp_hit,
  output logic [WAY_W-1:0]   o_resp_way,
  output logic               o_resp_dirty,
  output logic               o_victim_valid,
  output logic               o_victim_dirty,
  output logic [TAG_W-1:0]   o_victim_tag
);

  localparam int         SETS       = 1 << INDEX_W;
  localparam logic [1:0] OP_LOOKUP  = 2'b00;
  localparam logic [1:0] OP_LOOK_WR = 2'b01;
  localparam logic [1:0] OP_FILL    = 2'b10;
  localparam logic [1:0] OP_INVAL   = 2'b11;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic [INDEX_W-1:0] r_clear_idx;

  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAYS-1:0]  r_dirty [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];

  logic               r_resp_valid;
  logic               r_resp_hit;
  logic [WAY_W-1:0]   r_resp_way;
  logic               r_resp_dirty;
  logic               r_victim_valid;
  logic               r_victim_dirty;
  logic [TAG_W-1:0]   r_victim_tag;

  logic               w_accept;
  logic [WAYS-1:0]    w_set_valid;
  logic [WAYS-1:0]    w_set_dirty;
  logic [WAY_W-1:0]   w_set_rr;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic               w_hit_dirty;
  logic               w_has_free;
  logic [WAY_W-1:0]   w_free_way;
  logic [WAY_W-1:0]   w_victim_way;
  logic [WAY_W-1:0]   w_rr_nxt;

  // Reset is folded in so the array reports busy even before the first reset edge.
  assign o_busy  = (r_state == S_INIT) || i_reset;
  assign o_ready = ~o_busy;
  assign w_accept = i_req_valid && o_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_INIT;
      r_clear_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_clear_idx <= r_clear_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_clear_idx == {INDEX_W{1'b1}}) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign w_set_valid = r_valid[i_req_index];
  assign w_set_dirty = r_dirty[i_req_index];
  assign w_set_rr    = r_rr[i_req_index];

  // Descending scan so the lowest-numbered matching / free way is the one kept.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_set_valid[w] && (r_tag[i_req_index][w] == i_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_set_valid[w]) begin
        w_has_free = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
  end

  assign w_hit_dirty  = w_hit & w_set_dirty[w_hit_way];
  assign w_victim_way = w_has_free ? w_free_way : w_set_rr;
  assign w_rr_nxt     = (w_set_rr == WAY_W'(WAYS - 1)) ? '0 : w_set_rr + 1'b1;

  // Tags are never cleared; valid gates every use of them.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      if (r_state == S_INIT) begin
        r_valid[r_clear_idx] <= '0;
        r_dirty[r_clear_idx] <= '0;
        r_rr[r_clear_idx]    <= '0;
      end else if (w_accept) begin
        case (i_req_op)
          OP_LOOK_WR: begin
            if (w_hit) r_dirty[i_req_index][w_hit_way] <= 1'b1;
          end
          OP_FILL: begin
            r_tag[i_req_index][w_victim_way]   <= i_req_tag;
            r_valid[i_req_index][w_victim_way] <= 1'b1;
            r_dirty[i_req_index][w_victim_way] <= i_req_dirty;
            if (!w_has_free) r_rr[i_req_index] <= w_rr_nxt;
          end
          OP_INVAL: begin
            if (w_hit) begin
              r_valid[i_req_index][w_hit_way] <= 1'b0;
              r_dirty[i_req_index][w_hit_way] <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_resp_valid   <= 1'b0;
      r_resp_hit     <= 1'b0;
      r_resp_way     <= '0;
      r_resp_dirty   <= 1'b0;
      r_victim_valid <= 1'b0;
      r_victim_dirty <= 1'b0;
      r_victim_tag   <= '0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      if (i_req_op == OP_FILL) begin
        r_resp_hit     <= 1'b0;
        r_resp_way     <= w_victim_way;
        r_resp_dirty   <= 1'b0;
        r_victim_valid <= w_set_valid[w_victim_way];
        r_victim_dirty <= w_set_dirty[w_victim_way];
        r_victim_tag   <= r_tag[i_req_index][w_victim_way];
      end else begin
        r_resp_hit     <= w_hit;
        r_resp_way     <= w_hit_way;
        r_resp_dirty   <= w_hit_dirty;
        r_victim_valid <= 1'b0;
        r_victim_dirty <= 1'b0;
        r_victim_tag   <= '0;
      end
    end else begin
      r_resp_valid <= 1'b0;
    end
  end

  assign o_resp_valid   = r_resp_valid;
  assign o_resp_hit     = r_resp_hit;
  assign o_resp_way     = r_resp_way;
  assign o_resp_dirty   = r_resp_dirty;
  assign o_victim_valid = r_victim_valid;
  assign o_victim_dirty = r_victim_dirty;
  assign o_victim_tag   = r_victim_tag;

endmodule

// File: tb/tb_cache_tag_array.sv
// Directed bench for cache_tag_array: 8 sets, 2 ways, 4-bit tags.
module tb_cache_tag_array;

  localparam int TAG_W   = 4;
  localparam int INDEX_W = 3;
  localparam int WAYS    = 2;
  localparam int WAY_W   = 1;
  localparam int SETS    = 8;

  localparam logic [1:0] LOOKUP  = 2'b00;
  localparam logic [1:0] LOOK_WR = 2'b01;
  localparam logic [1:0] FILL    = 2'b10;
  localparam logic [1:0] INVAL   = 2'b11;

  logic               clk;
  logic               reset;
  logic               req_valid;
  logic [1:0]         req_op;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               req_dirty;
  logic               ready;
  logic               busy;
  logic               resp_valid;
  logic               resp_hit;
  logic [WAY_W-1:0]   resp_way;
  logic               resp_dirty;
  logic               victim_valid;
  logic               victim_dirty;
  logic [TAG_W-1:0]   victim_tag;

  int n_cmp  = 0;
  int n_fail = 0;

  cache_tag_array #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_req_valid    (req_valid),
    .i_req_op       (req_op),
    .i_req_index    (req_index),
    .i_req_tag      (req_tag),
    .i_req_dirty    (req_dirty),
    .o_ready        (ready),
    .o_busy         (busy),
    .o_resp_valid   (resp_valid),
    .o_resp_hit     (resp_hit),
    .o_resp_way     (resp_way),
    .o_resp_dirty   (resp_dirty),
    .o_victim_valid (victim_valid),
    .o_victim_dirty (victim_dirty),
    .o_victim_tag   (victim_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge; the response is sampled just after that edge.
  task automatic do_req(input logic [1:0] op, input logic [INDEX_W-1:0] idx,
                        input logic [TAG_W-1:0] tag, input logic d);
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_tag   = tag;
    req_dirty = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    for (int i = 0; i < SETS; i++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_no_resp"}, resp_valid, 0);
      tick();
    end
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = LOOKUP;
    req_index = '0;
    req_tag   = '0;
    req_dirty = 1'b0;

    // Reset for two cycles with a request held throughout reset and INIT.
    req_valid = 1'b1;
    req_index = 3'd5;
    req_tag   = 4'd3;
    tick();
    tick();
    check("rst_busy", busy, 1);
    check("rst_ready", ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_victim_valid", victim_valid, 0);
    reset = 1'b0;
    wait_init("init1");
    req_valid = 1'b0;

    // Single set, miss then fill then hit.
    do_req(LOOKUP, 3'd5, 4'd3, 1'b0);
    check("lk5_valid", resp_valid, 1);
    check("lk5_hit", resp_hit, 0);
    do_req(FILL, 3'd5, 4'd3, 1'b0);
    check("fill5_valid", resp_valid, 1);
    check("fill5_way", resp_way, 0);
    check("fill5_vvalid", victim_valid, 0);
    do_req(LOOKUP, 3'd5, 4'd3, 1'b0);
    check("lk5b_hit", resp_hit, 1);
    check("lk5b_way", resp_way, 0);
    check("lk5b_dirty", resp_dirty, 0);
    tick();
    check("idle_resp_valid", resp_valid, 0);
    check("idle_hold_hit", resp_hit, 1);

    // Two-way set: free-way fills, dirty marking, round-robin replacement.
    do_req(FILL, 3'd1, 4'd1, 1'b0);
    check("f1_way", resp_way, 0);
    do_req(FILL, 3'd1, 4'd2, 1'b0);
    check("f2_way", resp_way, 1);
    check("f2_vvalid", victim_valid, 0);
    do_req(LOOK_WR, 3'd1, 4'd1, 1'b0);
    check("lw1_hit", resp_hit, 1);
    check("lw1_dirty_pre", resp_dirty, 0);
    do_req(LOOKUP, 3'd1, 4'd1, 1'b0);
    check("lk1_dirty_post", resp_dirty, 1);
    do_req(FILL, 3'd1, 4'd4, 1'b0);
    check("f4_hit", resp_hit, 0);
    check("f4_way", resp_way, 0);
    check("f4_vvalid", victim_valid, 1);
    check("f4_vdirty", victim_dirty, 1);
    check("f4_vtag", victim_tag, 1);
    do_req(FILL, 3'd1, 4'd5, 1'b0);
    check("f5_way", resp_way, 1);
    check("f5_vvalid", victim_valid, 1);
    check("f5_vdirty", victim_dirty, 0);
    check("f5_vtag", victim_tag, 2);

    // Invalidate, repeat invalidate, then refill into the freed way.
    do_req(INVAL, 3'd1, 4'd4, 1'b0);
    check("inv4_hit", resp_hit, 1);
    check("inv4_way", resp_way, 0);
    check("inv4_dirty", resp_dirty, 0);
    check("inv4_vvalid", victim_valid, 0);
    check("inv4_vtag", victim_tag, 0);
    do_req(INVAL, 3'd1, 4'd4, 1'b0);
    check("inv4b_hit", resp_hit, 0);
    do_req(FILL, 3'd1, 4'd6, 1'b0);
    check("f6_way", resp_way, 0);
    check("f6_vvalid", victim_valid, 0);
    do_req(LOOKUP, 3'd1, 4'd5, 1'b0);
    check("lk5_way1", resp_way, 1);
    check("lk5_hit1", resp_hit, 1);

    // Back-to-back fill and lookup on consecutive edges.
    do_req(FILL, 3'd2, 4'd9, 1'b1);
    check("b2b_fill_way", resp_way, 0);
    do_req(LOOKUP, 3'd2, 4'd9, 1'b0);
    check("b2b_valid", resp_valid, 1);
    check("b2b_hit", resp_hit, 1);
    check("b2b_dirty", resp_dirty, 1);

    // Reset with a request present: response dropped, outputs forced low.
    req_valid = 1'b1;
    req_op    = LOOKUP;
    req_index = 3'd2;
    req_tag   = 4'd9;
    reset     = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rrun_resp_valid", resp_valid, 0);
    check("rrun_resp_hit", resp_hit, 0);
    check("rrun_busy", busy, 1);
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("midinit_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_init("init2");

    // Contents were cleared by the second init pass.
    do_req(LOOKUP, 3'd2, 4'd9, 1'b0);
    check("post_rst_hit_a", resp_hit, 0);
    do_req(LOOKUP, 3'd5, 4'd3, 1'b0);
    check("post_rst_hit_b", resp_hit, 0);
    do_req(FILL, 3'd1, 4'd7, 1'b0);
    check("post_rst_fill_way", resp_way, 0);
    check("post_rst_fill_vvalid", victim_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: compared %0d, expected the sequence to finish", n_cmp);
    $fatal(1);
  end

endmodule
